// File: rtl/cvtshift_if.sv
// cvtshift_if: handshake and data bundle for cvtshift_pipe.
//   master : producer/consumer side (drives beats in, accepts results)
//   slave  : the pipeline itself
// Signals:
//   InValid/InReady      input beat handshake
//   Flush                drop every in-flight beat
//   XZero, ToInt, IntToFp, CvtResSubnormUf, OutFmt, CvtCe, Xm, CvtLzcIn,
//   ShiftAmt             conversion operands captured with the beat
//   OutValid/OutReady    output beat handshake
//   Shifted, CvtResUf    shifted result and its underflow flag
interface cvtshift_if #(
    parameter int NE     = 11,
    parameter int NF     = 52,
    parameter int CVTLEN = 64
);
    localparam int W  = CVTLEN + NF + 1;
    localparam int SW = $clog2(W);

    logic              InValid;
    logic              InReady;
    logic              Flush;
    logic              XZero;
    logic              ToInt;
    logic              IntToFp;
    logic              CvtResSubnormUf;
    logic [1:0]        OutFmt;
    logic [NE:0]       CvtCe;
    logic [NF:0]       Xm;
    logic [CVTLEN-1:0] CvtLzcIn;
    logic [SW-1:0]     ShiftAmt;
    logic              OutValid;
    logic              OutReady;
    logic [W-1:0]      Shifted;
    logic              CvtResUf;

    modport master (
        output InValid, Flush, XZero, ToInt, IntToFp, CvtResSubnormUf,
               OutFmt, CvtCe, Xm, CvtLzcIn, ShiftAmt, OutReady,
        input  InReady, OutValid, Shifted, CvtResUf
    );

    modport slave (
        input  InValid, Flush, XZero, ToInt, IntToFp, CvtResSubnormUf,
               OutFmt, CvtCe, Xm, CvtLzcIn, ShiftAmt, OutReady,
        output InReady, OutValid, Shifted, CvtResUf
    );
endinterface

// File: rtl/cvtshift_pipe.sv
// cvtshift_pipe: pipelined conversion left-shifter.
// At capture the shift input is formed from the conversion operands and the
// underflow flag is computed; the left shift is then split over STAGES
// register stages, each stage consuming its own slice of ShiftAmt.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; clears all valid bits and outputs
//   bus    cvtshift_if slave modport (in/out handshakes, operands, results)
module cvtshift_pipe #(
    parameter int NE     = 11,
    parameter int NF     = 52,
    parameter int XLEN   = 64,
    parameter int CVTLEN = 64,
    parameter int NFMT   = 4,
    parameter int NF0    = 52,
    parameter int NF1    = 23,
    parameter int NF2    = 10,
    parameter int NF3    = 112,
    parameter int STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    cvtshift_if.slave   bus
);
    localparam int W   = CVTLEN + NF + 1;
    localparam int SW  = $clog2(W);
    localparam int NW  = $clog2(NF) + 1;
    localparam int CEW = NE + 1;
    localparam int C   = (SW + STAGES - 1) / STAGES;

    // Negated fraction lengths at NW bits; a length that does not fit a
    // signed NW-bit negative wraps, matching the original width choice.
    localparam logic signed [NW-1:0] NEG0 = -NW'(NF0);
    localparam logic signed [NW-1:0] NEG1 = -NW'(NF1);
    localparam logic signed [NW-1:0] NEG2 = -NW'(NF2);
    localparam logic signed [NW-1:0] NEG3 = -NW'(NF3);

    // Shift-amount bits handled by stage s: [s*C, min((s+1)*C, SW)-1].
    function automatic logic [SW-1:0] stage_mask(input int unsigned s);
        logic [SW-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < SW; i++) begin
            if (i >= s * C && i < (s + 1) * C) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    // ------------------------------------------------------------------
    // Capture-side operand formation
    // ------------------------------------------------------------------
    logic [W-1:0]           shin;
    logic signed [NW-1:0]   negnf;
    logic                   uf_in;

    always_comb begin
        shin = '0;
        if (bus.ToInt) begin
            shin[CVTLEN-XLEN +: NF+1] = {bus.Xm[NF] & ~bus.CvtCe[NE],
                                         bus.Xm[NF-1] | (bus.CvtCe[NE] & bus.Xm[NF]),
                                         bus.Xm[NF-2:0]};
        end else if (bus.CvtResSubnormUf) begin
            shin[CVTLEN-NF+1 +: NF+1] = bus.Xm;
        end else begin
            shin = {bus.CvtLzcIn, {(NF+1){1'b0}}};
        end
    end

    always_comb begin
        negnf = '0;
        if (int'(bus.OutFmt) < NFMT) begin
            case (bus.OutFmt)
                2'd0:    negnf = NEG0;
                2'd1:    negnf = NEG1;
                2'd2:    negnf = NEG2;
                2'd3:    negnf = NEG3;
                default: negnf = '0;
            endcase
        end
    end

    assign uf_in = ($signed(bus.CvtCe) < CEW'(negnf)) & ~bus.XZero & ~bus.IntToFp;

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic [STAGES-1:0] v_q;
    logic [W-1:0]      data_q [STAGES];
    logic [SW-1:0]     amt_q  [STAGES];
    logic              uf_q   [STAGES];

    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] ld;
    logic              in_ready;

    // Advance chain resolved from the output backwards: a stage moves on
    // when its successor is empty or itself moving on.
    always_comb begin
        adv = '0;
        adv[STAGES-1] = v_q[STAGES-1] & bus.OutReady;
        for (int unsigned k = 1; k < STAGES; k++) begin
            adv[STAGES-1-k] = v_q[STAGES-1-k] & (~v_q[STAGES-k] | adv[STAGES-k]);
        end
    end

    assign in_ready = ~v_q[0] | adv[0];

    always_comb begin
        ld = '0;
        ld[0] = bus.InValid & in_ready & ~bus.Flush;
        for (int unsigned k = 1; k < STAGES; k++) begin
            ld[k] = adv[k-1] & ~bus.Flush;
        end
    end

    // ------------------------------------------------------------------
    // Per-stage datapath
    // ------------------------------------------------------------------
    logic [W-1:0]  src_d [STAGES];
    logic [SW-1:0] src_a [STAGES];
    logic          src_u [STAGES];
    logic [W-1:0]  nxt_d [STAGES];

    always_comb begin
        for (int unsigned s = 0; s < STAGES; s++) begin
            src_d[s] = '0;
            src_a[s] = '0;
            src_u[s] = 1'b0;
            nxt_d[s] = '0;
        end
        src_d[0] = shin;
        src_a[0] = bus.ShiftAmt;
        src_u[0] = uf_in;
        for (int unsigned s = 1; s < STAGES; s++) begin
            src_d[s] = data_q[s-1];
            src_a[s] = amt_q[s-1];
            src_u[s] = uf_q[s-1];
        end
        // Partial shifts compose to the full shift; any total >= W
        // naturally leaves all zeros.
        for (int unsigned s = 0; s < STAGES; s++) begin
            nxt_d[s] = src_d[s] << (src_a[s] & stage_mask(s));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q <= '0;
            for (int unsigned s = 0; s < STAGES; s++) begin
                data_q[s] <= '0;
                amt_q[s]  <= '0;
                uf_q[s]   <= 1'b0;
            end
        end else begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                if (bus.Flush) begin
                    v_q[s] <= 1'b0;
                end else if (ld[s]) begin
                    v_q[s] <= 1'b1;
                end else if (adv[s]) begin
                    v_q[s] <= 1'b0;
                end
                if (ld[s]) begin
                    data_q[s] <= nxt_d[s];
                    amt_q[s]  <= src_a[s];
                    uf_q[s]   <= src_u[s];
                end
            end
        end
    end

    assign bus.InReady  = in_ready;
    assign bus.OutValid = v_q[STAGES-1];
    assign bus.Shifted  = data_q[STAGES-1];
    assign bus.CvtResUf = uf_q[STAGES-1];

endmodule

// File: tb/tb_cvtshift_pipe.sv
// tb_cvtshift_pipe: directed and random checks of cvtshift_pipe with a
// scoreboard of expected results pushed at input transfer and popped when
// the output handshake completes.
module tb_cvtshift_pipe;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cvtshift_if #(.NE(11), .NF(52), .CVTLEN(64)) bus();

    cvtshift_pipe #(
        .NE(11), .NF(52), .XLEN(64), .CVTLEN(64), .NFMT(4),
        .NF0(52), .NF1(23), .NF2(10), .NF3(112), .STAGES(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic ready_req = 1'b0;
    logic rnd_ready = 1'b0;
    logic rnd_bit   = 1'b0;
    assign bus.OutReady = rnd_ready ? rnd_bit : ready_req;
    always @(posedge clk) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    typedef struct packed {
        logic [116:0] sh;
        logic         uf;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic toint, input logic subuf, input logic xz,
                                   input logic i2f, input logic [1:0] fmt, input logic [11:0] ce,
                                   input logic [52:0] xm, input logic [63:0] lzc,
                                   input logic [6:0] amt);
        exp_t r;
        logic [116:0] v;
        int negnf;
        if (toint)
            v = {64'b0, xm[52] & ~ce[11], xm[51] | (ce[11] & xm[52]), xm[50:0]};
        else if (subuf)
            v = {51'b0, xm, 13'b0};
        else
            v = {lzc, 53'b0};
        r.sh = (amt >= 7'd117) ? '0 : (v << amt);
        case (fmt)
            2'd0:    negnf = -52;
            2'd1:    negnf = -23;
            2'd2:    negnf = -10;
            default: negnf = 16;
        endcase
        r.uf = (int'($signed(ce)) < negnf) && !xz && !i2f;
        return r;
    endfunction

    // Output monitor: scoreboard pop on handshake, stability while stalled.
    logic         held = 1'b0;
    logic [116:0] held_sh;
    logic         held_uf;
    exp_t         got;
    always @(negedge clk) begin
        if (reset) begin
            held = 1'b0;
        end else begin
            if (held && bus.OutValid) begin
                check("stall_shifted", bus.Shifted, held_sh);
                check("stall_uf", bus.CvtResUf, held_uf);
            end
            if (bus.OutValid && bus.OutReady) begin
                n_cmp++;
                assert (sb.size() > 0) else begin
                    n_err++;
                    $error("FAIL unexpected_beat observed=%0h expected=none", bus.Shifted);
                end
                if (sb.size() > 0) begin
                    got = sb.pop_front();
                    check("shifted", bus.Shifted, got.sh);
                    check("uf", bus.CvtResUf, got.uf);
                end
            end
            held    = bus.OutValid && !bus.OutReady;
            held_sh = bus.Shifted;
            held_uf = bus.CvtResUf;
        end
    end

    task automatic send(input logic toint, input logic subuf, input logic xz, input logic i2f,
                        input logic [1:0] fmt, input logic [11:0] ce, input logic [52:0] xm,
                        input logic [63:0] lzc, input logic [6:0] amt);
        bit done = 1'b0;
        bus.ToInt = toint; bus.CvtResSubnormUf = subuf; bus.XZero = xz; bus.IntToFp = i2f;
        bus.OutFmt = fmt; bus.CvtCe = ce; bus.Xm = xm; bus.CvtLzcIn = lzc; bus.ShiftAmt = amt;
        bus.InValid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.InReady) begin
                sb.push_back(model(toint, subuf, xz, i2f, fmt, ce, xm, lzc, amt));
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.InValid = 1'b0;
        n_cmp++;
        assert (done) else begin
            n_err++;
            $error("FAIL send_timeout observed=InReady_low expected=transfer");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() > 0; i++) @(posedge clk);
        #1;
        check("drain_empty", sb.size(), 0);
    endtask

    localparam logic [52:0] XM1 = 53'h1 << 52;
    localparam logic [63:0] LZ  = 64'hDEAD_BEEF_0123_4567;

    initial begin
        reset = 1'b1;
        bus.InValid = 1'b0; bus.Flush = 1'b0; bus.XZero = 1'b0; bus.ToInt = 1'b0;
        bus.IntToFp = 1'b0; bus.CvtResSubnormUf = 1'b0; bus.OutFmt = 2'd0;
        bus.CvtCe = '0; bus.Xm = '0; bus.CvtLzcIn = '0; bus.ShiftAmt = '0;
        #1;
        check("rst_outvalid", bus.OutValid, 0);
        check("rst_shifted", bus.Shifted, 0);
        check("rst_uf", bus.CvtResUf, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("post_rst_outvalid", bus.OutValid, 0);
        check("post_rst_inready", bus.InReady, 1);
        @(posedge clk); #1;

        // Latency: captured at edge k, visible after edge k+1.
        ready_req = 1'b1;
        send(1, 0, 0, 0, 2'd0, 12'h3FF, XM1, 64'h0, 7'd0);
        @(negedge clk);
        check("lat_first_cycle", bus.OutValid, 0);
        @(negedge clk);
        check("lat_second_cycle", bus.OutValid, 1);
        check("toint_shift0", bus.Shifted, 117'h1 << 52);
        @(posedge clk); #1;

        send(1, 0, 0, 0, 2'd0, 12'h3FF, XM1, 64'h0, 7'd12);
        send(1, 0, 0, 0, 2'd0, 12'hFFF, XM1, 64'h0, 7'd0);
        send(0, 1, 0, 0, 2'd0, 12'h000, XM1, 64'h0, 7'd0);
        send(0, 1, 0, 0, 2'd0, 12'h000, XM1, 64'h0, 7'd120);
        send(0, 0, 0, 0, 2'd0, 12'hFCB, XM1, LZ, 7'd3);   // -53 fmt0
        send(0, 0, 0, 0, 2'd0, 12'hFCC, XM1, LZ, 7'd3);   // -52 fmt0
        send(0, 0, 1, 0, 2'd0, 12'hFCB, XM1, LZ, 7'd3);   // XZero masks
        send(0, 0, 0, 1, 2'd0, 12'hFCB, XM1, LZ, 7'd3);   // IntToFp masks
        send(0, 0, 0, 0, 2'd1, 12'hFE8, XM1, LZ, 7'd64);  // -24 fmt1
        send(0, 0, 0, 0, 2'd2, 12'hFF5, XM1, LZ, 7'd116); // -11 fmt2
        send(0, 0, 0, 0, 2'd0, 12'h000, XM1, LZ, 7'd117);
        drain();

        // Backpressure: two beats fill the pipe, third waits.
        ready_req = 1'b0;
        send(0, 0, 0, 0, 2'd0, 12'h001, XM1, 64'h1, 7'd1);
        send(0, 0, 0, 0, 2'd0, 12'h002, XM1, 64'h2, 7'd2);
        repeat (3) begin
            @(negedge clk);
            check("full_inready", bus.InReady, 0);
            check("full_outvalid", bus.OutValid, 1);
        end
        @(posedge clk); #1;
        ready_req = 1'b1;
        send(0, 0, 0, 0, 2'd0, 12'h003, XM1, 64'h3, 7'd3);
        drain();

        // Flush with two beats in flight, output consumed in the same cycle.
        ready_req = 1'b0;
        send(1, 0, 0, 0, 2'd0, 12'h3FF, XM1, 64'h0, 7'd4);
        send(1, 0, 0, 0, 2'd0, 12'h3FF, XM1, 64'h0, 7'd5);
        bus.Flush = 1'b1;
        ready_req = 1'b1;
        bus.ToInt = 1'b0; bus.CvtLzcIn = LZ; bus.ShiftAmt = 7'd0;
        bus.InValid = 1'b1;
        @(negedge clk);
        check("flush_cycle_inready", bus.InReady, 1);
        @(posedge clk); #1;
        bus.Flush = 1'b0;
        bus.InValid = 1'b0;
        sb.delete();
        @(negedge clk);
        check("post_flush_inready", bus.InReady, 1);
        repeat (4) begin
            check("post_flush_outvalid", bus.OutValid, 0);
            @(negedge clk);
        end
        @(posedge clk); #1;

        // Asynchronous reset with a stalled beat at the output.
        ready_req = 1'b0;
        send(1, 0, 0, 0, 2'd0, 12'hFCB, XM1, 64'h0, 7'd5);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_outvalid", bus.OutValid, 1);
        #3 reset = 1'b1;
        #1;
        check("async_rst_outvalid", bus.OutValid, 0);
        check("async_rst_shifted", bus.Shifted, 0);
        check("async_rst_uf", bus.CvtResUf, 0);
        check("async_rst_inready", bus.InReady, 1);
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rerst_outvalid", bus.OutValid, 0);
        check("rerst_inready", bus.InReady, 1);
        @(posedge clk); #1;

        // Random beats under random output backpressure.
        rnd_ready = 1'b1;
        for (int n = 0; n < 30; n++) begin
            send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                 2'($urandom_range(0, 2)), 12'($urandom_range(0, 4095)),
                 53'({$urandom, $urandom}), {$urandom, $urandom},
                 7'($urandom_range(0, 127)));
        end
        rnd_ready = 1'b0;
        ready_req = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
